// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter slice.
package ram_arb_pkg;

    localparam int MaxReq = 8;

    typedef logic [MaxReq-1:0] grant_t;

    // Address width for a given word count; never narrower than one bit.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps at NumReq-1.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NumReq = 2,
    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [PtrW-1:0]   idx,
    output logic              any
);

    logic            any_s;
    logic [PtrW-1:0] idx_s;
    grant_t          onehot_s;

    // Upper pass covers ptr..NumReq-1; the lower pass covers the wrapped range 0..ptr-1.
    always_comb begin
        any_s    = 1'b0;
        idx_s    = '0;
        onehot_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx_s = (!any_s && req[i] && (PtrW'(i) >= ptr)) ? PtrW'(i) : idx_s;
            any_s = any_s | (req[i] && (PtrW'(i) >= ptr));
        end
        for (int i = 0; i < NumReq; i++) begin
            idx_s = (!any_s && req[i] && (PtrW'(i) < ptr)) ? PtrW'(i) : idx_s;
            any_s = any_s | (req[i] && (PtrW'(i) < ptr));
        end
        onehot_s = any_s ? (grant_t'(1'b1) << idx_s) : grant_t'(1'b0);
    end

    assign gnt = onehot_s[NumReq-1:0];
    assign idx = idx_s;
    assign any = any_s;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharing of one simple dual-port RAM between NumReq requesters.
// Define RAM_ARB_BYPASS_EN to forward same-cycle write data into a colliding read response.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int Width  = 8,
    parameter int Depth  = 16,
    parameter int NumReq = 2,
    localparam int AW    = calc_aw(Depth),
    localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NumReq-1:0]       reqWrValid,
    output logic [NumReq-1:0]       reqWrReady,
    input  logic [NumReq*AW-1:0]    reqWrAddr,
    input  logic [NumReq*Width-1:0] reqWrData,
    input  logic [NumReq-1:0]       reqRdValid,
    output logic [NumReq-1:0]       reqRdReady,
    input  logic [NumReq*AW-1:0]    reqRdAddr,
    output logic [NumReq-1:0]       rspRdValid,
    output logic [Width-1:0]        rspRdData,
    output logic                    memWrEn,
    output logic [AW-1:0]           memWrAddr,
    output logic [Width-1:0]        memWrData,
    output logic [AW-1:0]           memRdAddr,
    input  logic [Width-1:0]        memRdData
);

    logic [NumReq-1:0] wr_gnt_s;
    logic [NumReq-1:0] rd_gnt_s;
    logic [PtrW-1:0]   wr_idx_s;
    logic [PtrW-1:0]   rd_idx_s;
    logic              wr_any_s;
    logic              rd_any_s;
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [PtrW-1:0]   wr_ptr_nxt_s;
    logic [PtrW-1:0]   rd_ptr_nxt_s;
    logic [NumReq-1:0] rsp_valid_r;
    logic [AW-1:0]     wr_addr_s;
    logic [Width-1:0]  wr_data_s;
    logic [AW-1:0]     rd_addr_s;

    rr_arbiter #(.NumReq(NumReq)) u_wr_arb (
        .req (reqWrValid),
        .ptr (wr_ptr_r),
        .gnt (wr_gnt_s),
        .idx (wr_idx_s),
        .any (wr_any_s)
    );

    rr_arbiter #(.NumReq(NumReq)) u_rd_arb (
        .req (reqRdValid),
        .ptr (rd_ptr_r),
        .gnt (rd_gnt_s),
        .idx (rd_idx_s),
        .any (rd_any_s)
    );

    // One-hot AND-OR mux so the RAM sees zeros rather than stale fields when idle.
    always_comb begin
        wr_addr_s = '0;
        wr_data_s = '0;
        rd_addr_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            wr_addr_s = wr_addr_s | (reqWrAddr[i*AW +: AW] & {AW{wr_gnt_s[i]}});
            wr_data_s = wr_data_s | (reqWrData[i*Width +: Width] & {Width{wr_gnt_s[i]}});
            rd_addr_s = rd_addr_s | (reqRdAddr[i*AW +: AW] & {AW{rd_gnt_s[i]}});
        end
    end

    assign wr_ptr_nxt_s = (wr_idx_s == PtrW'(NumReq - 1)) ? '0 : wr_idx_s + 1'b1;
    assign rd_ptr_nxt_s = (rd_idx_s == PtrW'(NumReq - 1)) ? '0 : rd_idx_s + 1'b1;

    // Pointers advance past the winner only on a granted cycle; the strobe tracks RAM read latency.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            rsp_valid_r <= '0;
        end else begin
            wr_ptr_r    <= wr_any_s ? wr_ptr_nxt_s : wr_ptr_r;
            rd_ptr_r    <= rd_any_s ? rd_ptr_nxt_s : rd_ptr_r;
            rsp_valid_r <= rd_gnt_s;
        end
    end

    assign reqWrReady = wr_gnt_s;
    assign reqRdReady = rd_gnt_s;
    assign memWrEn    = wr_any_s;
    assign memWrAddr  = wr_addr_s;
    assign memWrData  = wr_data_s;
    assign memRdAddr  = rd_addr_s;
    assign rspRdValid = rsp_valid_r;

`ifdef RAM_ARB_BYPASS_EN
    logic             hit_flag_r;
    logic [Width-1:0] hit_data_r;

    // Capture a write colliding with a granted read so the response shows the new data.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hit_flag_r <= 1'b0;
            hit_data_r <= '0;
        end else begin
            hit_flag_r <= wr_any_s && rd_any_s && (wr_addr_s == rd_addr_s);
            hit_data_r <= wr_data_s;
        end
    end

    assign rspRdData = hit_flag_r ? hit_data_r : memRdData;
`else
    assign rspRdData = memRdData;
`endif

endmodule
